// File: rtl/spi_chain_master.sv
// rtl/spi_chain_master.sv - byte-stream SPI master, mode 0, MSB first, frames delimited by iTX_LAST
// Optional feature: SPI_LOOPBACK_EN adds iLOOPBACK to sample MOSI instead of MISO.
module spi_chain_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_HOLD = 2
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic [7:0] iTX_DATA,
    input  logic       iTX_VALID,
    input  logic       iTX_LAST,
    output logic       oTX_READY,
    output logic [7:0] oRX_DATA,
    output logic       oRX_VALID,
    output logic       oBUSY,
    output logic       oSPI_SCLK,
    output logic       oSPI_MOSI,
    output logic       oSPI_CSn,
    input  logic       iSPI_MISO
`ifdef SPI_LOOPBACK_EN
    ,
    input  logic       iLOOPBACK
`endif
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int HOLD_W = $clog2(CS_HOLD + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, TAIL, HOLD} state_t;

    state_t            state;
    logic [DIV_W-1:0]  divCnt;
    logic [HOLD_W-1:0] holdCnt;
    logic [3:0]        bitCnt;
    logic [7:0]        shTx;
    logic [7:0]        shRx;
    logic              lastLatched;
    logic              accept;
    logic              divEnd;
    logic              rxBit;

    assign accept = iTX_VALID & oTX_READY;
    assign divEnd = (divCnt == DIV_LAST);

`ifdef SPI_LOOPBACK_EN
    assign rxBit = iLOOPBACK ? oSPI_MOSI : iSPI_MISO;
`else
    assign rxBit = iSPI_MISO;
`endif

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state       <= IDLE;
            divCnt      <= '0;
            holdCnt     <= '0;
            bitCnt      <= '0;
            shTx        <= '0;
            shRx        <= '0;
            lastLatched <= 1'b0;
            oTX_READY   <= 1'b0;
            oRX_DATA    <= 8'h00;
            oRX_VALID   <= 1'b0;
            oBUSY       <= 1'b0;
            oSPI_SCLK   <= 1'b0;
            oSPI_MOSI   <= 1'b0;
            oSPI_CSn    <= 1'b1;
        end else begin
            oRX_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    oSPI_CSn  <= 1'b1;
                    oSPI_SCLK <= 1'b0;
                    if (accept) begin
                        shTx        <= {iTX_DATA[6:0], 1'b0};
                        oSPI_MOSI   <= iTX_DATA[7];
                        lastLatched <= iTX_LAST;
                        oSPI_CSn    <= 1'b0;
                        oTX_READY   <= 1'b0;
                        oBUSY       <= 1'b1;
                        divCnt      <= '0;
                        bitCnt      <= '0;
                        state       <= SETUP;
                    end else begin
                        oTX_READY <= 1'b1;
                    end
                end
                SETUP: begin
                    divCnt <= divEnd ? '0 : divCnt + 1'b1;
                    if (divEnd) state <= SHIFT;
                end
                SHIFT: begin
                    if (divEnd) begin
                        divCnt    <= '0;
                        oSPI_SCLK <= ~oSPI_SCLK;
                        bitCnt    <= bitCnt + 4'd1;
                        // SCLK currently low: this edge rises, so capture the slave bit
                        if (!oSPI_SCLK) begin
                            shRx <= {shRx[6:0], rxBit};
                        end else if (bitCnt == 4'd15) begin
                            oRX_DATA  <= shRx;
                            oRX_VALID <= 1'b1;
                            oTX_READY <= ~lastLatched;
                            bitCnt    <= '0;
                            state     <= GAP;
                        end else begin
                            oSPI_MOSI <= shTx[7];
                            shTx      <= {shTx[6:0], 1'b0};
                        end
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end
                GAP: begin
                    if (lastLatched) begin
                        divCnt <= '0;
                        state  <= TAIL;
                    end else if (accept) begin
                        shTx        <= {iTX_DATA[6:0], 1'b0};
                        oSPI_MOSI   <= iTX_DATA[7];
                        lastLatched <= iTX_LAST;
                        oTX_READY   <= 1'b0;
                        divCnt      <= '0;
                        bitCnt      <= '0;
                        state       <= SETUP;
                    end
                end
                TAIL: begin
                    if (divEnd) begin
                        divCnt   <= '0;
                        holdCnt  <= '0;
                        oSPI_CSn <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (holdCnt == HOLD_LAST) begin
                        holdCnt   <= '0;
                        oTX_READY <= 1'b1;
                        oBUSY     <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_chain_master.sv
// tb/tb_spi_chain_master.sv - directed bench for spi_chain_master (CLK_DIV=4 and CLK_DIV=1 instances)
module tb_spi_chain_master;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    int         cyc = 0;
    int         nAssert = 0;
    int         nFail = 0;

    logic [7:0] txData = 8'h00;
    logic       txValid = 1'b0;
    logic       txLast = 1'b0;
    logic       txReady, rxValid, busy, sclk, mosi, csn, misoPin;
    logic [7:0] rxData;
    logic       tieHigh = 1'b0;
    logic       slaveMiso = 1'b0;
    logic       loopback = 1'b0;

    logic [7:0] tx1Data = 8'h00;
    logic       tx1Valid = 1'b0;
    logic       tx1Last = 1'b0;
    logic       tx1Ready, rx1Valid, busy1, sclk1, mosi1, csn1;
    logic [7:0] rx1Data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign misoPin = tieHigh ? 1'b1 : slaveMiso;

    spi_chain_master #(.CLK_DIV(4), .CS_HOLD(2)) dut (
        .iCLK(clk), .iRESETn(rstN),
        .iTX_DATA(txData), .iTX_VALID(txValid), .iTX_LAST(txLast), .oTX_READY(txReady),
        .oRX_DATA(rxData), .oRX_VALID(rxValid), .oBUSY(busy),
        .oSPI_SCLK(sclk), .oSPI_MOSI(mosi), .oSPI_CSn(csn), .iSPI_MISO(misoPin)
`ifdef SPI_LOOPBACK_EN
        , .iLOOPBACK(loopback)
`endif
    );

    spi_chain_master #(.CLK_DIV(1), .CS_HOLD(2)) dut1 (
        .iCLK(clk), .iRESETn(rstN),
        .iTX_DATA(tx1Data), .iTX_VALID(tx1Valid), .iTX_LAST(tx1Last), .oTX_READY(tx1Ready),
        .oRX_DATA(rx1Data), .oRX_VALID(rx1Valid), .oBUSY(busy1),
        .oSPI_SCLK(sclk1), .oSPI_MOSI(mosi1), .oSPI_CSn(csn1), .iSPI_MISO(1'b0)
`ifdef SPI_LOOPBACK_EN
        , .iLOOPBACK(1'b0)
`endif
    );

    // Slave model: mode 0, presents bit7 when selected, shifts on SCLK falling edges
    logic [7:0] slaveQ[$];
    logic [7:0] slaveByte = 8'h00;
    logic [7:0] mosiSh = 8'h00;
    logic [7:0] mosiLog[$];
    logic [7:0] rxLog[$];
    int         rxCyc[$];
    int         slaveBit = 0;
    int         riseCnt = 0;
    int         csFallCnt = 0;
    int         csRiseCyc = -1;
    logic       csPrev = 1'b1;
    logic [7:0] rx1Log[$];
    int         rx1Cyc[$];
    int         sclk1Rise[$];
    logic       sclk1Prev = 1'b0;

    function automatic logic [7:0] nextSlave();
        if (slaveQ.size() > 0) return slaveQ.pop_front();
        return 8'h00;
    endfunction

    always @(negedge csn) begin
        slaveBit  = 0;
        slaveByte = nextSlave();
        slaveMiso = slaveByte[7];
    end

    always @(posedge sclk) begin
        riseCnt++;
        mosiSh = {mosiSh[6:0], mosi};
    end

    always @(negedge sclk) begin
        if (!csn) begin
            slaveBit++;
            if (slaveBit == 8) begin
                slaveBit = 0;
                mosiLog.push_back(mosiSh);
                slaveByte = nextSlave();
            end else begin
                slaveByte = {slaveByte[6:0], 1'b0};
            end
            slaveMiso = slaveByte[7];
        end
    end

    always @(negedge clk) begin
        if (rxValid) begin rxLog.push_back(rxData); rxCyc.push_back(cyc); end
        if (csn && !csPrev) csRiseCyc = cyc;
        if (!csn && csPrev) csFallCnt++;
        csPrev = csn;
        if (rx1Valid) begin rx1Log.push_back(rx1Data); rx1Cyc.push_back(cyc); end
        if (sclk1 && !sclk1Prev) sclk1Rise.push_back(cyc);
        sclk1Prev = sclk1;
    end

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAssert++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearLogs();
        slaveQ.delete(); mosiLog.delete(); rxLog.delete(); rxCyc.delete();
        riseCnt = 0; csFallCnt = 0; csRiseCyc = -1;
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge
    task automatic pushByte(input logic [7:0] d, input logic last, output int acc);
        acc = -1;
        txData = d; txValid = 1'b1; txLast = last;
        for (int i = 0; i < 300; i++) begin
            if (txReady) begin acc = cyc + 1; break; end
            @(negedge clk);
        end
        if (acc < 0) checkValue("accept timeout", 32'd0, 32'd1);
        @(negedge clk);
        txValid = 1'b0; txLast = 1'b0; txData = 8'h00;
    endtask

    task automatic waitIdle(output int readyCyc);
        readyCyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && txReady) begin readyCyc = cyc; break; end
        end
        if (readyCyc < 0) checkValue("idle timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, acc3, rdy, stallBad;

        // Power-on reset state
        repeat (3) @(negedge clk);
        checkValue("rst csn", csn, 1);
        checkValue("rst sclk", sclk, 0);
        checkValue("rst mosi", mosi, 0);
        checkValue("rst ready", txReady, 0);
        checkValue("rst rxvalid", rxValid, 0);
        checkValue("rst rxdata", rxData, 8'h00);
        checkValue("rst busy", busy, 0);
        rstN = 1'b1;
        @(negedge clk);
        checkValue("ready after release", txReady, 1);

        // T1: reset mid-SHIFT while SCLK and MOSI are high
        clearLogs();
        pushByte(8'hFF, 1'b1, acc);
        repeat (9) @(negedge clk);
        checkValue("t1 sclk high before reset", sclk, 1);
        checkValue("t1 mosi high before reset", mosi, 1);
        rstN = 1'b0;
        #1;
        checkValue("t1 csn async", csn, 1);
        checkValue("t1 sclk async", sclk, 0);
        checkValue("t1 mosi async", mosi, 0);
        checkValue("t1 rxvalid async", rxValid, 0);
        checkValue("t1 busy async", busy, 0);
        @(negedge clk);
        rstN = 1'b1;
        checkValue("t1 ready at release", txReady, 0);
        @(negedge clk);
        checkValue("t1 ready 1 clk after", txReady, 1);
        repeat (80) @(negedge clk);
        checkValue("t1 no partial rx", rxLog.size(), 0);

        // T2: single byte A5 out, 3C back
        clearLogs();
        slaveQ.push_back(8'h3C);
        pushByte(8'hA5, 1'b1, acc);
        waitIdle(rdy);
        checkValue("t2 rx count", rxLog.size(), 1);
        if (rxLog.size() == 1) begin
            checkValue("t2 rx data", rxLog[0], 8'h3C);
            checkValue("t2 rx latency", rxCyc[0] - acc, 68);
        end
        checkValue("t2 mosi count", mosiLog.size(), 1);
        if (mosiLog.size() == 1) checkValue("t2 mosi byte", mosiLog[0], 8'hA5);
        checkValue("t2 sclk rises", riseCnt, 8);
        checkValue("t2 cs rise", csRiseCyc - acc, 68 + 1 + 4);
        checkValue("t2 ready return", rdy - acc, 68 + 1 + 4 + 2);

        // T3: three-byte frame under one chip select
        clearLogs();
        slaveQ.push_back(8'hC1); slaveQ.push_back(8'hD2); slaveQ.push_back(8'hE3);
        pushByte(8'h01, 1'b0, acc);
        pushByte(8'h02, 1'b0, acc2);
        pushByte(8'h83, 1'b1, acc3);
        waitIdle(rdy);
        checkValue("t3 cs falls", csFallCnt, 1);
        checkValue("t3 sclk rises", riseCnt, 24);
        checkValue("t3 rx count", rxLog.size(), 3);
        checkValue("t3 mosi count", mosiLog.size(), 3);
        if (rxLog.size() == 3 && mosiLog.size() == 3) begin
            checkValue("t3 rx0", rxLog[0], 8'hC1);
            checkValue("t3 rx1", rxLog[1], 8'hD2);
            checkValue("t3 rx2", rxLog[2], 8'hE3);
            checkValue("t3 mosi0", mosiLog[0], 8'h01);
            checkValue("t3 mosi1", mosiLog[1], 8'h02);
            checkValue("t3 mosi2", mosiLog[2], 8'h83);
            checkValue("t3 gap accept", acc2 - rxCyc[0], 1);
            checkValue("t3 byte spacing", rxCyc[1] - rxCyc[0], 69);
        end

        // T4: source stalls mid-frame
        clearLogs();
        slaveQ.push_back(8'h66); slaveQ.push_back(8'h99);
        pushByte(8'h10, 1'b0, acc);
        for (int i = 0; i < 200 && rxLog.size() == 0; i++) @(negedge clk);
        checkValue("t4 first rx", rxLog.size(), 1);
        stallBad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (csn !== 1'b0 || sclk !== 1'b0 || txReady !== 1'b1) stallBad++;
        end
        checkValue("t4 stall holds bus", stallBad, 0);
        pushByte(8'h20, 1'b1, acc2);
        waitIdle(rdy);
        checkValue("t4 cs falls", csFallCnt, 1);
        checkValue("t4 rx count", rxLog.size(), 2);
        checkValue("t4 mosi count", mosiLog.size(), 2);
        if (rxLog.size() == 2 && mosiLog.size() == 2) begin
            checkValue("t4 rx0", rxLog[0], 8'h66);
            checkValue("t4 rx1", rxLog[1], 8'h99);
            checkValue("t4 mosi0", mosiLog[0], 8'h10);
            checkValue("t4 mosi1", mosiLog[1], 8'h20);
            checkValue("t4 latency", rxCyc[1] - acc2, 68);
        end

        // T5: CLK_DIV=1 instance, MISO tied low
        rx1Log.delete(); rx1Cyc.delete(); sclk1Rise.delete();
        acc = -1;
        tx1Data = 8'hFF; tx1Valid = 1'b1; tx1Last = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (tx1Ready) begin acc = cyc + 1; break; end
            @(negedge clk);
        end
        checkValue("t5 accepted", acc >= 0, 1);
        @(negedge clk);
        tx1Valid = 1'b0; tx1Last = 1'b0;
        for (int i = 0; i < 60 && !(busy1 == 1'b0 && rx1Log.size() > 0); i++) @(negedge clk);
        checkValue("t5 rx count", rx1Log.size(), 1);
        if (rx1Log.size() == 1) begin
            checkValue("t5 rx data", rx1Log[0], 8'h00);
            checkValue("t5 rx latency", rx1Cyc[0] - acc, 17);
        end
        checkValue("t5 sclk rises", sclk1Rise.size(), 8);
        if (sclk1Rise.size() >= 2) begin
            checkValue("t5 first rise", sclk1Rise[0] - acc, 2);
            checkValue("t5 sclk period", sclk1Rise[1] - sclk1Rise[0], 2);
        end

`ifdef SPI_LOOPBACK_EN
        // T6: loopback ignores the MISO pin
        clearLogs();
        tieHigh = 1'b1; loopback = 1'b1;
        pushByte(8'h5A, 1'b1, acc);
        waitIdle(rdy);
        checkValue("t6 rx count", rxLog.size(), 1);
        if (rxLog.size() == 1) checkValue("t6 loopback data", rxLog[0], 8'h5A);
        tieHigh = 1'b0; loopback = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
